// File: rtl/feature_update_alu.sv
// ---------------------------------------------------------------------------
// feature_update_alu
//
// Per-flow feature update stage. Takes one aligned packet (size, inter-arrival)
// plus the cached flow history and produces:
//   * a write-back word for the main feature memory (updated max/min size and
//     inter-arrival plus a 10-pair history vector, newest pair at [15:0]),
//   * a completed flow record, pushed into a small valid/ready FIFO whenever
//     the flow reaches its packet threshold.
//
// Pipeline: stage A registers every input each cycle; the update is computed
// combinationally from A and registered into stage B, which drives o_wr_*.
// Latency input -> o_wr_v is two cycles, one packet per cycle sustained.
//
// Optional feature (macro FEATURE_FWD_EN):
//   defined   - a packet whose hash matches the packet currently in stage B
//               (distance 1) uses the stage B results as its history source.
//   undefined - cached inputs are always used as the history source.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_size_arit_v            packet valid
//   i_pkt_size/arit/n_pkt    packet size, inter-arrival, flow packet count
//   i_hash                   flow hash
//   i_reach_thrh             flow reached its packet threshold
//   i_cache_data_v           cached history valid (hash hit)
//   i_max/min_pkt_size/arit  cached statistics
//   i_vec_feature            cached 10-pair history
//   o_wr_*                   write-back word (o_wr_clr: invalidate entry)
//   o_rec_*, i_rec_rdy       flow record FIFO head, valid/ready handshake
//   o_drop_cnt               saturating count of records dropped on full FIFO
// ---------------------------------------------------------------------------
module feature_update_alu #(
  parameter int REC_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_size_arit_v,
  input  logic [7:0]   i_pkt_size,
  input  logic [7:0]   i_pkt_arit,
  input  logic [7:0]   i_n_pkt,
  input  logic [31:0]  i_hash,
  input  logic         i_reach_thrh,
  input  logic         i_cache_data_v,
  input  logic [7:0]   i_max_pkt_size,
  input  logic [7:0]   i_min_pkt_size,
  input  logic [7:0]   i_max_pkt_arit,
  input  logic [7:0]   i_min_pkt_arit,
  input  logic [159:0] i_vec_feature,
  output logic         o_wr_v,
  output logic         o_wr_clr,
  output logic [31:0]  o_wr_hash,
  output logic [7:0]   o_wr_max_size,
  output logic [7:0]   o_wr_min_size,
  output logic [7:0]   o_wr_max_arit,
  output logic [7:0]   o_wr_min_arit,
  output logic [159:0] o_wr_vec,
  output logic         o_rec_v,
  input  logic         i_rec_rdy,
  output logic [31:0]  o_rec_hash,
  output logic [7:0]   o_rec_n_pkt,
  output logic [31:0]  o_rec_stats,
  output logic [159:0] o_rec_vec,
  output logic [15:0]  o_drop_cnt
);

  localparam int PW = $clog2(REC_DEPTH);
  localparam int CW = $clog2(REC_DEPTH) + 1;

  typedef struct packed {
    logic [31:0]  hash;
    logic [7:0]   n_pkt;
    logic [31:0]  stats;
    logic [159:0] vec;
  } rec_t;

  // -------------------------------------------------------------------------
  // Stage A: plain input register
  // -------------------------------------------------------------------------
  logic         a_v_reg;
  logic [7:0]   a_size_reg;
  logic [7:0]   a_arit_reg;
  logic [7:0]   a_n_pkt_reg;
  logic [31:0]  a_hash_reg;
  logic         a_thrh_reg;
  logic         a_cache_v_reg;
  logic [7:0]   a_max_size_reg;
  logic [7:0]   a_min_size_reg;
  logic [7:0]   a_max_arit_reg;
  logic [7:0]   a_min_arit_reg;
  logic [159:0] a_vec_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_v_reg        <= 1'b0;
      a_size_reg     <= '0;
      a_arit_reg     <= '0;
      a_n_pkt_reg    <= '0;
      a_hash_reg     <= '0;
      a_thrh_reg     <= 1'b0;
      a_cache_v_reg  <= 1'b0;
      a_max_size_reg <= '0;
      a_min_size_reg <= '0;
      a_max_arit_reg <= '0;
      a_min_arit_reg <= '0;
      a_vec_reg      <= '0;
    end else begin
      a_v_reg        <= i_size_arit_v;
      a_size_reg     <= i_pkt_size;
      a_arit_reg     <= i_pkt_arit;
      a_n_pkt_reg    <= i_n_pkt;
      a_hash_reg     <= i_hash;
      a_thrh_reg     <= i_reach_thrh;
      a_cache_v_reg  <= i_cache_data_v;
      a_max_size_reg <= i_max_pkt_size;
      a_min_size_reg <= i_min_pkt_size;
      a_max_arit_reg <= i_max_pkt_arit;
      a_min_arit_reg <= i_min_pkt_arit;
      a_vec_reg      <= i_vec_feature;
    end
  end

  // -------------------------------------------------------------------------
  // Stage B registers (declared early: they feed the forwarding path)
  // -------------------------------------------------------------------------
  logic         b_v_reg;
  logic         b_clr_reg;
  logic [31:0]  b_hash_reg;
  logic [7:0]   b_max_size_reg;
  logic [7:0]   b_min_size_reg;
  logic [7:0]   b_max_arit_reg;
  logic [7:0]   b_min_arit_reg;
  logic [159:0] b_vec_reg;

  // -------------------------------------------------------------------------
  // Source select and update compute
  // -------------------------------------------------------------------------
  logic         fwd;
  logic         hit;
  logic [7:0]   src_max_size;
  logic [7:0]   src_min_size;
  logic [7:0]   src_max_arit;
  logic [7:0]   src_min_arit;
  logic [159:0] src_vec;

  always_comb begin
    fwd = 1'b0;
`ifdef FEATURE_FWD_EN
    // A cleared entry is being invalidated in memory, so it must not seed the
    // next packet of the same flow.
    fwd = b_v_reg && (b_hash_reg == a_hash_reg) && !b_clr_reg;
`endif
    hit          = a_cache_v_reg | fwd;
    src_max_size = fwd ? b_max_size_reg : a_max_size_reg;
    src_min_size = fwd ? b_min_size_reg : a_min_size_reg;
    src_max_arit = fwd ? b_max_arit_reg : a_max_arit_reg;
    src_min_arit = fwd ? b_min_arit_reg : a_min_arit_reg;
    src_vec      = fwd ? b_vec_reg      : a_vec_reg;
  end

  logic [7:0]   new_max_size;
  logic [7:0]   new_min_size;
  logic [7:0]   new_max_arit;
  logic [7:0]   new_min_arit;
  logic [159:0] new_vec;

  // On a miss the packet itself is the only sample, so all extremes equal it.
  assign new_max_size = (hit && (src_max_size > a_size_reg)) ? src_max_size : a_size_reg;
  assign new_min_size = (hit && (src_min_size < a_size_reg)) ? src_min_size : a_size_reg;
  assign new_max_arit = (hit && (src_max_arit > a_arit_reg)) ? src_max_arit : a_arit_reg;
  assign new_min_arit = (hit && (src_min_arit < a_arit_reg)) ? src_min_arit : a_arit_reg;

  // History shifts up by one pair; the oldest pair (src_vec[159:144]) falls off.
  assign new_vec[15:0] = {a_size_reg, a_arit_reg};
  for (genvar gi = 1; gi < 10; gi++) begin : g_vec_shift
    assign new_vec[gi*16 +: 16] = hit ? src_vec[(gi-1)*16 +: 16] : 16'd0;
  end

  // -------------------------------------------------------------------------
  // Stage B: write-back word. Data holds over invalid cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_v_reg        <= 1'b0;
      b_clr_reg      <= 1'b0;
      b_hash_reg     <= '0;
      b_max_size_reg <= '0;
      b_min_size_reg <= '0;
      b_max_arit_reg <= '0;
      b_min_arit_reg <= '0;
      b_vec_reg      <= '0;
    end else begin
      b_v_reg   <= a_v_reg;
      b_clr_reg <= a_v_reg & a_thrh_reg;
      if (a_v_reg) begin
        b_hash_reg     <= a_hash_reg;
        b_max_size_reg <= new_max_size;
        b_min_size_reg <= new_min_size;
        b_max_arit_reg <= new_max_arit;
        b_min_arit_reg <= new_min_arit;
        b_vec_reg      <= new_vec;
      end
    end
  end

  assign o_wr_v        = b_v_reg;
  assign o_wr_clr      = b_clr_reg;
  assign o_wr_hash     = b_hash_reg;
  assign o_wr_max_size = b_max_size_reg;
  assign o_wr_min_size = b_min_size_reg;
  assign o_wr_max_arit = b_max_arit_reg;
  assign o_wr_min_arit = b_min_arit_reg;
  assign o_wr_vec      = b_vec_reg;

  // -------------------------------------------------------------------------
  // Flow record FIFO
  // -------------------------------------------------------------------------
  rec_t          rec_mem [REC_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [15:0]   drop_cnt_reg;

  logic rec_empty;
  logic rec_full;
  logic push;
  logic pop;
  logic push_ok;
  logic drop;
  rec_t new_rec;
  rec_t head;

  assign rec_empty = (count_reg == '0);
  assign rec_full  = (count_reg == CW'(REC_DEPTH));
  assign push      = a_v_reg & a_thrh_reg;
  assign pop       = !rec_empty & i_rec_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push & (!rec_full | pop);
  assign drop      = push & rec_full & !pop;

  assign new_rec.hash  = a_hash_reg;
  assign new_rec.n_pkt = a_n_pkt_reg;
  assign new_rec.stats = {new_max_size, new_min_size, new_max_arit, new_min_arit};
  assign new_rec.vec   = new_vec;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      rec_mem[wr_ptr_reg] <= new_rec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  // Head fields are masked while empty so nothing stale or uninitialised leaks.
  assign head        = rec_mem[rd_ptr_reg];
  assign o_rec_v     = !rec_empty;
  assign o_rec_hash  = rec_empty ? 32'd0  : head.hash;
  assign o_rec_n_pkt = rec_empty ? 8'd0   : head.n_pkt;
  assign o_rec_stats = rec_empty ? 32'd0  : head.stats;
  assign o_rec_vec   = rec_empty ? 160'd0 : head.vec;
  assign o_drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_feature_update_alu.sv
// ---------------------------------------------------------------------------
// tb_feature_update_alu
//
// Directed scenarios followed by randomized traffic, checked against a
// transaction-level reference model: each packet's update is computed from
// its history source, write-backs are expected two cycles after the input,
// and flow records go through a bounded queue with drop counting.
// ---------------------------------------------------------------------------
module tb_feature_update_alu;

  localparam int REC_DEPTH = 2;

  logic         clk;
  logic         rst;
  logic         i_size_arit_v;
  logic [7:0]   i_pkt_size;
  logic [7:0]   i_pkt_arit;
  logic [7:0]   i_n_pkt;
  logic [31:0]  i_hash;
  logic         i_reach_thrh;
  logic         i_cache_data_v;
  logic [7:0]   i_max_pkt_size;
  logic [7:0]   i_min_pkt_size;
  logic [7:0]   i_max_pkt_arit;
  logic [7:0]   i_min_pkt_arit;
  logic [159:0] i_vec_feature;
  logic         o_wr_v;
  logic         o_wr_clr;
  logic [31:0]  o_wr_hash;
  logic [7:0]   o_wr_max_size;
  logic [7:0]   o_wr_min_size;
  logic [7:0]   o_wr_max_arit;
  logic [7:0]   o_wr_min_arit;
  logic [159:0] o_wr_vec;
  logic         o_rec_v;
  logic         i_rec_rdy;
  logic [31:0]  o_rec_hash;
  logic [7:0]   o_rec_n_pkt;
  logic [31:0]  o_rec_stats;
  logic [159:0] o_rec_vec;
  logic [15:0]  o_drop_cnt;

  feature_update_alu #(.REC_DEPTH(REC_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_size_arit_v  (i_size_arit_v),
    .i_pkt_size     (i_pkt_size),
    .i_pkt_arit     (i_pkt_arit),
    .i_n_pkt        (i_n_pkt),
    .i_hash         (i_hash),
    .i_reach_thrh   (i_reach_thrh),
    .i_cache_data_v (i_cache_data_v),
    .i_max_pkt_size (i_max_pkt_size),
    .i_min_pkt_size (i_min_pkt_size),
    .i_max_pkt_arit (i_max_pkt_arit),
    .i_min_pkt_arit (i_min_pkt_arit),
    .i_vec_feature  (i_vec_feature),
    .o_wr_v         (o_wr_v),
    .o_wr_clr       (o_wr_clr),
    .o_wr_hash      (o_wr_hash),
    .o_wr_max_size  (o_wr_max_size),
    .o_wr_min_size  (o_wr_min_size),
    .o_wr_max_arit  (o_wr_max_arit),
    .o_wr_min_arit  (o_wr_min_arit),
    .o_wr_vec       (o_wr_vec),
    .o_rec_v        (o_rec_v),
    .i_rec_rdy      (i_rec_rdy),
    .o_rec_hash     (o_rec_hash),
    .o_rec_n_pkt    (o_rec_n_pkt),
    .o_rec_stats    (o_rec_stats),
    .o_rec_vec      (o_rec_vec),
    .o_drop_cnt     (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [31:0]  hash;
    logic [7:0]   size;
    logic [7:0]   arit;
    logic [7:0]   n_pkt;
    logic         thrh;
    logic         cache_v;
    logic [7:0]   mxs;
    logic [7:0]   mns;
    logic [7:0]   mxa;
    logic [7:0]   mna;
    logic [159:0] vec;
  } pkt_t;

  typedef struct packed {
    logic [31:0]  hash;
    logic [7:0]   n_pkt;
    logic         clr;
    logic [7:0]   mxs;
    logic [7:0]   mns;
    logic [7:0]   mxa;
    logic [7:0]   mna;
    logic [159:0] vec;
  } res_t;

  int   total = 0;
  int   bad   = 0;

  pkt_t pend;
  res_t last;
  bit   last_v;
  res_t exp_wr;
  bit   exp_wr_v;
  res_t rec_q[$];
  logic [15:0] drops;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  // Reference update: history comes either from the cache or, when the
  // previous packet was the same live flow, from that packet's result.
  function automatic res_t compute(input pkt_t p, input bit use_prev, input res_t prev);
    res_t r;
    logic [7:0]   smxs, smns, smxa, smna;
    logic [159:0] sv;
    bit hit;
    hit  = p.cache_v || use_prev;
    smxs = use_prev ? prev.mxs : p.mxs;
    smns = use_prev ? prev.mns : p.mns;
    smxa = use_prev ? prev.mxa : p.mxa;
    smna = use_prev ? prev.mna : p.mna;
    sv   = use_prev ? prev.vec : p.vec;
    r.hash  = p.hash;
    r.n_pkt = p.n_pkt;
    r.clr   = p.thrh;
    if (hit) begin
      r.mxs = max8(smxs, p.size);
      r.mns = min8(smns, p.size);
      r.mxa = max8(smxa, p.arit);
      r.mna = min8(smna, p.arit);
      r.vec = (sv << 16) | {144'd0, p.size, p.arit};
    end else begin
      r.mxs = p.size;
      r.mns = p.size;
      r.mxa = p.arit;
      r.mna = p.arit;
      r.vec = {144'd0, p.size, p.arit};
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] hash, input logic [7:0] size,
                       input logic [7:0] arit, input logic [7:0] n_pkt, input logic thrh,
                       input logic cache_v, input logic [7:0] mxs, input logic [7:0] mns,
                       input logic [7:0] mxa, input logic [7:0] mna, input logic [159:0] vec);
    i_size_arit_v  = v;
    i_hash         = hash;
    i_pkt_size     = size;
    i_pkt_arit     = arit;
    i_n_pkt        = n_pkt;
    i_reach_thrh   = thrh;
    i_cache_data_v = cache_v;
    i_max_pkt_size = mxs;
    i_min_pkt_size = mns;
    i_max_pkt_arit = mxa;
    i_min_pkt_arit = mna;
    i_vec_feature  = vec;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 160'd0);
  endtask

  task automatic check_outputs();
    chk("wr_v", o_wr_v, exp_wr_v);
    if (exp_wr_v) begin
      chk("wr_clr",      o_wr_clr,      exp_wr.clr);
      chk("wr_hash",     o_wr_hash,     exp_wr.hash);
      chk("wr_max_size", o_wr_max_size, exp_wr.mxs);
      chk("wr_min_size", o_wr_min_size, exp_wr.mns);
      chk("wr_max_arit", o_wr_max_arit, exp_wr.mxa);
      chk("wr_min_arit", o_wr_min_arit, exp_wr.mna);
      chk("wr_vec",      o_wr_vec,      exp_wr.vec);
    end else begin
      chk("wr_clr_idle", o_wr_clr, 1'b0);
    end
    chk("rec_v", o_rec_v, rec_q.size() > 0);
    if (rec_q.size() > 0) begin
      chk("rec_hash",  o_rec_hash,  rec_q[0].hash);
      chk("rec_n_pkt", o_rec_n_pkt, rec_q[0].n_pkt);
      chk("rec_stats", o_rec_stats, {rec_q[0].mxs, rec_q[0].mns, rec_q[0].mxa, rec_q[0].mna});
      chk("rec_vec",   o_rec_vec,   rec_q[0].vec);
    end
    chk("drop_cnt", o_drop_cnt, drops);
  endtask

  // One clock: the packet captured at the previous edge completes at this edge.
  task automatic step();
    pkt_t cur;
    res_t r;
    bit   use_prev;
    cur = {i_size_arit_v, i_hash, i_pkt_size, i_pkt_arit, i_n_pkt, i_reach_thrh,
           i_cache_data_v, i_max_pkt_size, i_min_pkt_size, i_max_pkt_arit,
           i_min_pkt_arit, i_vec_feature};
    @(posedge clk);
    if (rec_q.size() > 0 && i_rec_rdy) rec_q.delete(0);
    exp_wr_v = pend.v;
    r = '0;
    if (pend.v) begin
      use_prev = 1'b0;
`ifdef FEATURE_FWD_EN
      use_prev = last_v && (last.hash == pend.hash) && !last.clr;
`endif
      r = compute(pend, use_prev, last);
      exp_wr = r;
      if (pend.thrh) begin
        if (rec_q.size() < REC_DEPTH) rec_q.push_back(r);
        else if (drops != 16'hFFFF) drops = drops + 16'd1;
      end
      $display("txn hash=%08h size=%02h arit=%02h thrh=%0d -> max=%02h min=%02h", pend.hash,
               pend.size, pend.arit, pend.thrh, r.mxs, r.mns);
    end
    last_v = pend.v;
    if (pend.v) last = r;
    pend = cur;
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    rec_q.delete();
    drops    = 16'd0;
    pend     = '0;
    last     = '0;
    last_v   = 1'b0;
    exp_wr   = '0;
    exp_wr_v = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_v"},     o_wr_v,        1'b0);
    chk({tag, "_wr_clr"},   o_wr_clr,      1'b0);
    chk({tag, "_wr_hash"},  o_wr_hash,     32'd0);
    chk({tag, "_wr_max"},   o_wr_max_size, 8'd0);
    chk({tag, "_wr_vec"},   o_wr_vec,      160'd0);
    chk({tag, "_rec_v"},    o_rec_v,       1'b0);
    chk({tag, "_rec_hash"}, o_rec_hash,    32'd0);
    chk({tag, "_rec_vec"},  o_rec_vec,     160'd0);
    chk({tag, "_drop"},     o_drop_cnt,    16'd0);
  endtask

  task automatic random_pkt();
    logic [31:0] h;
    h = ($urandom_range(0, 3) == 0) ? $urandom : 32'(32'h50 + $urandom_range(0, 2));
    drive($urandom_range(0, 3) != 0, h, 8'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 5) == 0, 1'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom),
          {$urandom, $urandom, $urandom, $urandom, $urandom});
    i_rec_rdy = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst       = 1'b1;
    i_rec_rdy = 1'b0;
    idle();
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Miss: history ignored, single-sample statistics.
    drive(1'b1, 32'h1, 8'h40, 8'h05, 8'd1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, {160{1'b1}});
    step();
    idle();
    step();
    chk("miss_vec", o_wr_vec, 160'h4005);
    chk("miss_max", o_wr_max_size, 8'h40);

    // Hit: new max, old min kept, oldest pair discarded.
    drive(1'b1, 32'h2, 8'h90, 8'h05, 8'd3, 1'b0, 1'b1, 8'h80, 8'h20, 8'h07, 8'h06,
          {16'hABCD, 128'd0, 16'h1111});
    step();
    idle();
    step();
    chk("hit_vec", o_wr_vec, 160'h1111_9005);
    chk("hit_max", o_wr_max_size, 8'h90);
    chk("hit_min", o_wr_min_size, 8'h20);

    // Back-to-back same hash, second packet a cache miss.
    drive(1'b1, 32'h33, 8'h10, 8'hA0, 8'd1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 160'd0);
    step();
    drive(1'b1, 32'h33, 8'h30, 8'hA1, 8'd2, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 160'd0);
    step();
    idle();
    step();
    step();
`ifdef FEATURE_FWD_EN
    chk("fwd_max", o_wr_max_size, 8'h30);
    chk("fwd_min", o_wr_min_size, 8'h10);
    chk("fwd_vec", o_wr_vec, 160'h10A0_30A1);
`endif

    // Three threshold packets into a two-entry FIFO with no consumer.
    i_rec_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h100 + 32'(k), 8'h20 + 8'(k), 8'h03, 8'd10, 1'b1, 1'b1,
            8'h40, 8'h10, 8'h09, 8'h01, 160'h1234);
      step();
    end
    idle();
    step();
    step();
    chk("thr_drop", o_drop_cnt, 16'd1);
    chk("thr_rec_v", o_rec_v, 1'b1);
    chk("thr_head", o_rec_hash, 32'h100);
    i_rec_rdy = 1'b1;
    step();
    chk("thr_head2", o_rec_hash, 32'h101);
    step();
    step();

    // Full FIFO: push and pop land on the same edge.
    i_rec_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h200 + 32'(k), 8'h55, 8'h66, 8'd20, 1'b1, 1'b0,
            8'h0, 8'h0, 8'h0, 8'h0, 160'd0);
      step();
    end
    drive(1'b1, 32'h202, 8'h77, 8'h88, 8'd21, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 160'd0);
    step();
    idle();
    i_rec_rdy = 1'b1;
    step();
    chk("pp_drop", o_drop_cnt, 16'd1);
    chk("pp_head", o_rec_hash, 32'h201);
    step();
    step();
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      random_pkt();
      step();
    end

    // Reset in the middle of traffic with a stalled consumer.
    i_rec_rdy = 1'b0;
    for (int n = 0; n < 6; n++) begin
      random_pkt();
      i_size_arit_v = 1'b1;
      i_reach_thrh  = 1'b1;
      i_rec_rdy     = 1'b0;
      step();
    end
    rst = 1'b1;
    #2;
    check_all_zero("midrst");
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 100; n++) begin
      random_pkt();
      step();
    end
    idle();
    i_rec_rdy = 1'b1;
    step();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feature_update_alu.md
# feature_update_alu

Per-flow feature update stage sitting directly downstream of the buffer-to-ALU alignment stage in the TFE pipeline. Takes the aligned 1-stage packet features plus the cached flow history and computes updated max/min size and inter-arrival statistics and a shifted 10-packet history vector. Emits a write-back word to the main feature memory and, when a flow reaches its packet threshold, a completed flow record to the classifier through a valid/ready FIFO.

## Interface
- REC_DEPTH, 2, flow-record FIFO entries (power of 2, ≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_size_arit_v  in  1  packet feature valid
- i_pkt_size / i_pkt_arit / i_n_pkt  in  8 each  current packet size, inter-arrival, flow packet count
- i_hash  in  32  flow hash
- i_reach_thrh  in  1  flow reached packet threshold with this packet
- i_cache_data_v  in  1  history data valid (hash hit), qualified by i_size_arit_v
- i_max_pkt_size / i_min_pkt_size / i_max_pkt_arit / i_min_pkt_arit  in  8 each  cached statistics
- i_vec_feature  in  160  cached history, 10 pairs {size,arit}, newest at [15:0]
- o_wr_v  out  1  write-back valid
- o_wr_clr  out  1  with o_wr_v: invalidate entry instead of storing
- o_wr_hash  out  32; o_wr_max_size / o_wr_min_size / o_wr_max_arit / o_wr_min_arit  out  8 each; o_wr_vec  out  160
- o_rec_v  out  1  flow record valid; i_rec_rdy  in  1  downstream ready
- o_rec_hash  out  32; o_rec_n_pkt  out  8; o_rec_stats  out  32 {max_size,min_size,max_arit,min_arit}; o_rec_vec  out  160
- o_drop_cnt  out  16  saturating count of records dropped on full FIFO

## Operation
- Stage A: registers all inputs every cycle; A_v = i_size_arit_v.
- Combinational compute from A, registered into stage B (write-back outputs).
- Source select: hit = A.cache_data_v; with forwarding (see Configuration), if B_v and B.hash == A.hash and !B.clr, source = B results and hit forced to 1.
- Hit: max = max(src_max, size), min = min(src_min, size), same for arit (unsigned 8-bit compares); vec = {src_vec[143:0], size, arit}.
- Miss: max=min=size, max_arit=min_arit=arit, vec = {144'd0, size, arit}.
- o_wr_clr = A.reach_thrh; statistics/vec still driven with computed values.
- Record push when A_v && A.reach_thrh: fields = computed values, n_pkt = A.n_pkt. FIFO full → record dropped, o_drop_cnt += 1 (saturate at 16'hFFFF).
- FIFO: o_rec_v = !empty, head fields on o_rec_*; pop when o_rec_v && i_rec_rdy. Push and pop same cycle when full: pop accepted, push accepted, no drop.
- Invalid A cycles: B_v = 0, B data fields hold previous value.

## Timing
- Latency i_size_arit_v → o_wr_v: 2 cycles; one packet per cycle sustained.
- Record: pushed at the same edge as o_wr_v rises; o_rec_v earliest 2 cycles after input if FIFO empty.
- o_rec_* stable while o_rec_v && !i_rec_rdy.
- Forwarding covers distance-1 back-to-back same-hash packets only; distance ≥2 relies on memory coherency.
- Reset: o_wr_v, o_wr_clr, o_rec_v = 0; all data outputs 0; o_drop_cnt = 0; FIFO empty; A_v = B_v = 0. Reset mid-operation discards in-flight packets and FIFO contents.

## Configuration
- FEATURE_FWD_EN defined: same-hash distance-1 forwarding from stage B into stage A source select as above.
- Undefined: cached inputs always used; back-to-back same-hash packets produce stale-based results (memory side must stall).

## Test plan
- Miss: size=0x40, arit=0x05, cache_v=0 → 2 cycles later o_wr_v=1, max=min=0x40, arit max=min=0x05, vec=0x...0000_4005.
- Hit: cache max=0x80,min=0x20, size=0x90, vec low=0x1111 → max=0x90, min=0x20, vec[31:0]=0x1111_9005, oldest pair discarded.
- Back-to-back same hash (FEATURE_FWD_EN) sizes 0x10 then 0x30, second cache_v=0 → second write max=0x30, min=0x10, vec[31:0]={0x10,a0,0x30,a1}.
- Threshold with i_rec_rdy=0: three reach_thrh packets, REC_DEPTH=2 → o_rec_v=1, two records held, o_drop_cnt=1, o_wr_clr=1 each time; then rdy=1 pops in order.
- Full FIFO push+pop same cycle → no drop, count stays, order preserved.
- Assert rst mid-stream → all outputs 0 next cycle, o_rec_v=0, o_drop_cnt=0.
